// File: rtl/bcd_clock_12h.sv
`default_nettype none
// ============================================================================
// Module   : bcd_clock_12h
// Purpose  : 12-hour hh:mm:ss BCD time-of-day counter with AM/PM flag and a
//            valid/ready time-set port. Optional alarm: BCD_CLOCK_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_clock_12h #(
  parameter logic [7:0] RESET_HH = 8'h12,
  parameter logic [7:0] RESET_MM = 8'h00,
  parameter logic       RESET_PM = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       set_pm,
  output logic       set_err,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
`ifdef BCD_CLOCK_ALARM_EN
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_pm,
  input  logic       alarm_arm,
  output logic       alarm,
`endif
  output logic       min_tick
);

  localparam logic [0:0] c_st_run  = 1'b0;
  localparam logic [0:0] c_st_hold = 1'b1;

  function automatic logic f_hh_ok(input logic [7:0] v);
    return ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
           ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
  endfunction

  function automatic logic f_ms_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  // Minute/second increment, 59 wraps to 00.
  function automatic logic [7:0] f_ms_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] f_hh_inc(input logic [7:0] v);
    if (v == 8'h12) return 8'h01;
    if (v == 8'h09) return 8'h10;
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [0:0] r_state, w_state_nxt;
  logic [7:0] r_hh, r_mm, r_ss;
  logic       r_pm, r_set_err, r_min_tick;

  logic       w_transfer, w_set_legal, w_load, w_run_tick;
  logic       w_ss_wrap, w_mm_wrap;
  logic [7:0] w_ss_nxt, w_mm_nxt, w_hh_nxt;
  logic       w_pm_nxt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_st_run;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run:  if (w_load)   w_state_nxt = c_st_hold;
      c_st_hold: if (sec_tick) w_state_nxt = c_st_run;
      default:                 w_state_nxt = c_st_run;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    set_ready = (r_state == c_st_run);
  end

  // A transfer (legal or not) always wins over a coincident tick.
  assign w_transfer  = set_valid && set_ready;
  assign w_set_legal = f_hh_ok(set_hh) && f_ms_ok(set_mm) && f_ms_ok(set_ss);
  assign w_load      = w_transfer && w_set_legal;
  assign w_run_tick  = sec_tick && set_ready && !w_transfer;

  // Corrupted fields snap back to their reset value and do not carry.
  always_comb begin
    w_ss_wrap = f_ms_ok(r_ss) && (r_ss == 8'h59);
    w_mm_wrap = w_ss_wrap && f_ms_ok(r_mm) && (r_mm == 8'h59);
    w_ss_nxt  = f_ms_ok(r_ss) ? f_ms_inc(r_ss) : 8'h00;
    w_mm_nxt  = !f_ms_ok(r_mm) ? RESET_MM : (w_ss_wrap ? f_ms_inc(r_mm) : r_mm);
    w_hh_nxt  = !f_hh_ok(r_hh) ? RESET_HH : (w_mm_wrap ? f_hh_inc(r_hh) : r_hh);
    w_pm_nxt  = r_pm ^ (w_mm_wrap && (r_hh == 8'h11));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hh       <= RESET_HH;
      r_mm       <= RESET_MM;
      r_ss       <= 8'h00;
      r_pm       <= RESET_PM;
      r_set_err  <= 1'b0;
      r_min_tick <= 1'b0;
    end else begin
      r_set_err  <= w_transfer && !w_set_legal;
      r_min_tick <= w_run_tick && w_ss_wrap;
      if (w_load) begin
        r_hh <= set_hh;
        r_mm <= set_mm;
        r_ss <= set_ss;
        r_pm <= set_pm;
      end else if (w_run_tick) begin
        r_hh <= w_hh_nxt;
        r_mm <= w_mm_nxt;
        r_ss <= w_ss_nxt;
        r_pm <= w_pm_nxt;
      end
    end
  end

`ifdef BCD_CLOCK_ALARM_EN
  logic r_alarm;

  // Only counting ticks can fire the alarm; a set landing on it cannot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_alarm <= 1'b0;
    else        r_alarm <= w_run_tick && alarm_arm &&
                           (w_hh_nxt == alarm_hh) && (w_mm_nxt == alarm_mm) &&
                           (w_ss_nxt == 8'h00) && (w_pm_nxt == alarm_pm);
  end

  assign alarm = r_alarm;
`endif

  assign hh       = r_hh;
  assign mm       = r_mm;
  assign ss       = r_ss;
  assign pm       = r_pm;
  assign set_err  = r_set_err;
  assign min_tick = r_min_tick;

endmodule
`default_nettype wire

// File: tb/tb_bcd_clock_12h.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_clock_12h
// Purpose  : Directed self-checking bench for bcd_clock_12h.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_clock_12h;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_tick = 1'b0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
  logic       set_pm = 1'b0;
  logic       set_err;
  logic [7:0] hh, mm, ss;
  logic       pm, min_tick;
`ifdef BCD_CLOCK_ALARM_EN
  logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic       alarm_pm = 1'b0, alarm_arm = 1'b0;
  logic       alarm;
`endif

  int errors = 0;
  int checks = 0;
  int mt_count;

  always #5 clk = ~clk;

  bcd_clock_12h dut (
    .clk       (clk),
    .reset     (reset),
    .sec_tick  (sec_tick),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
    .set_pm    (set_pm),
    .set_err   (set_err),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .pm        (pm),
`ifdef BCD_CLOCK_ALARM_EN
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_pm  (alarm_pm),
    .alarm_arm (alarm_arm),
    .alarm     (alarm),
`endif
    .min_tick  (min_tick)
  );

  function automatic logic [31:0] tm(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s, input logic p);
    return {7'd0, h, m, s, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic p);
    check(tag, tm(hh, mm, ss, pm), tm(h, m, s, p));
  endtask

  // One-cycle sec_tick; returns at the negedge after the edge that consumed it.
  task automatic tick();
    @(negedge clk); sec_tick = 1'b1;
    @(negedge clk); sec_tick = 1'b0;
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input logic p, input logic with_tick);
    @(negedge clk);
    set_hh = h; set_mm = m; set_ss = s; set_pm = p;
    set_valid = 1'b1; sec_tick = with_tick;
    @(negedge clk);
    set_valid = 1'b0; sec_tick = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_time("reset_time", 8'h12, 8'h00, 8'h00, 1'b0);
    check("reset_ready", {31'd0, set_ready}, 32'd1);
    check("reset_flags", {30'd0, set_err, min_tick}, 32'd0);
    reset = 1'b1;

    // 60 ticks from 12:00:00 AM
    mt_count = 0;
    for (int i = 0; i < 59; i++) begin
      tick();
      mt_count += int'(min_tick);
    end
    check_time("count_59", 8'h12, 8'h00, 8'h59, 1'b0);
    tick();
    check("min_tick_60th", {31'd0, min_tick}, 32'd1);
    mt_count += int'(min_tick);
    check_time("count_60", 8'h12, 8'h01, 8'h00, 1'b0);
    check("min_tick_once", mt_count, 32'd1);
    @(negedge clk);
    check("min_tick_drop", {31'd0, min_tick}, 32'd0);

    // 11:59:59 AM -> 12:00:00 PM
    do_set(8'h11, 8'h59, 8'h59, 1'b0, 1'b0);
    check_time("set_1159", 8'h11, 8'h59, 8'h59, 1'b0);
    check("hold_ready", {31'd0, set_ready}, 32'd0);
    tick();
    check_time("absorb_1159", 8'h11, 8'h59, 8'h59, 1'b0);
    check("run_ready", {31'd0, set_ready}, 32'd1);
    tick();
    check_time("noon", 8'h12, 8'h00, 8'h00, 1'b1);
    check("noon_min_tick", {31'd0, min_tick}, 32'd1);

    // 12:59:59 PM -> 01:00:00 PM
    do_set(8'h12, 8'h59, 8'h59, 1'b1, 1'b0);
    tick();
    check_time("absorb_1259", 8'h12, 8'h59, 8'h59, 1'b1);
    tick();
    check_time("one_pm", 8'h01, 8'h00, 8'h00, 1'b1);

    // Illegal sets
    do_set(8'h05, 8'h60, 8'h00, 1'b0, 1'b0);
    check("err_mm60", {30'd0, set_err, set_ready}, 32'd3);
    check_time("err_mm60_time", 8'h01, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    check("err_mm60_pulse", {31'd0, set_err}, 32'd0);
    do_set(8'h00, 8'h10, 8'h10, 1'b0, 1'b0);
    check("err_hh00", {30'd0, set_err, set_ready}, 32'd3);
    check_time("err_hh00_time", 8'h01, 8'h00, 8'h00, 1'b1);
    do_set(8'h04, 8'h10, 8'h1A, 1'b0, 1'b0);
    check("err_ss1a", {30'd0, set_err, set_ready}, 32'd3);
    check_time("err_ss1a_time", 8'h01, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    check("err_ss1a_pulse", {31'd0, set_err}, 32'd0);

    // Set coincident with tick at 03:15:20
    do_set(8'h03, 8'h15, 8'h20, 1'b0, 1'b0);
    tick();
    check_time("at_0315", 8'h03, 8'h15, 8'h20, 1'b0);
    do_set(8'h07, 8'h07, 8'h07, 1'b0, 1'b1);
    check_time("set_wins", 8'h07, 8'h07, 8'h07, 1'b0);
    check("set_wins_ready", {31'd0, set_ready}, 32'd0);
    do_set(8'h09, 8'h09, 8'h09, 1'b1, 1'b0);
    check_time("hold_ignores_set", 8'h07, 8'h07, 8'h07, 1'b0);
    check("hold_no_err", {30'd0, set_err, set_ready}, 32'd0);
    tick();
    check_time("absorb_0707", 8'h07, 8'h07, 8'h07, 1'b0);
    tick();
    check_time("after_0707", 8'h07, 8'h07, 8'h08, 1'b0);

    // Asynchronous reset between clock edges
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_time("async_reset", 8'h12, 8'h00, 8'h00, 1'b0);
    check("async_reset_ready", {31'd0, set_ready}, 32'd1);
    @(negedge clk); reset = 1'b1;

`ifdef BCD_CLOCK_ALARM_EN
    alarm_hh = 8'h06; alarm_mm = 8'h30; alarm_pm = 1'b0; alarm_arm = 1'b1;
    do_set(8'h06, 8'h30, 8'h00, 1'b0, 1'b0);
    check("alarm_set_no_fire", {31'd0, alarm}, 32'd0);
    do_set(8'h06, 8'h29, 8'h59, 1'b1, 1'b0);
    tick();
    tick();
    check("alarm_wrong_pm", {31'd0, alarm}, 32'd0);
    do_set(8'h06, 8'h29, 8'h58, 1'b0, 1'b0);
    mt_count = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mt_count += int'(alarm);
    end
    check_time("alarm_time", 8'h06, 8'h30, 8'h01, 1'b0);
    check("alarm_once", mt_count, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_clock_12h.md
Name: bcd_clock_12h

Overview:
- 12-hour hh:mm:ss BCD time-of-day counter with an AM/PM flag.
- Consumes the 1-per-second enable pulse produced by the 1000:1 BCD frequency divider stage directly upstream.
- Adds a valid/ready time-set handshake.
- Outputs drive the 7-segment display stage downstream.

Parameters:
- RESET_HH, 8'h12, BCD hour loaded on reset; legal range 01..12.
- RESET_MM, 8'h00, BCD minute loaded on reset; legal range 00..59.
- RESET_PM, 1'b0, AM/PM flag loaded on reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- sec_tick  in  1  one-cycle pulse, once per second (from the divider's one-hertz output)
- set_valid  in  1  time-set request
- set_ready  out  1  block can accept a set this cycle
- set_hh  in  8  BCD hour to load
- set_mm  in  8  BCD minute to load
- set_ss  in  8  BCD second to load
- set_pm  in  1  PM flag to load
- set_err  out  1  one-cycle pulse: offered set value illegal, rejected
- hh  out  8  BCD hour, 01..12
- mm  out  8  BCD minute, 00..59
- ss  out  8  BCD second, 00..59
- pm  out  1  1 = PM
- min_tick  out  1  one-cycle pulse when ss wraps 59->00

Behaviour:
- Reset (reset=0, asynchronous):
  - hh=RESET_HH, mm=RESET_MM, ss=8'h00, pm=RESET_PM.
  - set_err=0, min_tick=0, FSM=RUN.
  - Reset mid-count or mid-set discards everything.
- All outputs are registered.
- FSM RUN, set_ready=1:
  - sec_tick=1 -> ss increments in BCD; low nibble 9 -> 0 with carry into the high nibble.
  - ss 59 -> 00 carries to mm; mm 59 -> 00 carries to hh.
  - hh sequence: 12 -> 01 -> 02 ... 11 -> 12.
  - pm toggles only on the 11:59:59 -> 12:00:00 transition.
  - min_tick=1 in the cycle after the ss 59 -> 00 update (registered with it).
- Set handshake:
  - Transfer occurs when set_valid && set_ready.
  - Legality check: hh 01..12, mm 00..59, ss 00..59, every nibble <=9.
  - Legal -> next cycle hh/mm/ss/pm = set_*; FSM -> HOLD.
  - Illegal -> time unchanged, set_err=1 for one cycle, FSM stays RUN.
  - A transfer in the same cycle as sec_tick takes priority; that tick is dropped.
  - set_valid while set_ready=0 is ignored, with no error.
- FSM HOLD, set_ready=0:
  - Time is frozen.
  - The first sec_tick is absorbed (no increment) and FSM -> RUN, so the first increment after a set comes one full second later.
  - set_valid is ignored in HOLD.
- Unreachable BCD values (only reachable via X or corruption) -> next tick forces that field to its reset value.
- Latency: sec_tick at cycle N -> new time visible at N+1.

Optional Feature:
- Macro: BCD_CLOCK_ALARM_EN.
- Defined:
  - Adds inputs alarm_hh[8], alarm_mm[8], alarm_pm[1], alarm_arm[1] and output alarm[1].
  - alarm=1 for one cycle when a RUN-state tick produces hh:mm:ss == alarm_hh:alarm_mm:00 with pm == alarm_pm, while alarm_arm=1.
  - A set that lands exactly on the alarm time does not fire it.
  - alarm resets to 0.
- Undefined: these ports and the comparison logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with defaults, then 60 sec_tick pulses -> 12:00:00 AM -> 12:01:00 AM; min_tick pulses once, on the 60th tick.
- Set 11:59:59 AM, one absorbed tick, then one tick -> 12:00:00 PM, pm=1, min_tick=1.
- Set 12:59:59 PM, absorb, tick -> 01:00:00 PM, pm unchanged.
- set_valid with set_mm=8'h60, or set_hh=8'h00, or set_ss=8'h1A -> set_err single pulse, time unchanged, set_ready stays 1.
- set_valid and sec_tick in the same cycle at 03:15:20 with set 07:07:07 -> 07:07:07, no increment; set_ready=0 until the next tick, which is absorbed.
- reset asserted asynchronously mid-second (between clock edges) -> outputs return to RESET values immediately; with BCD_CLOCK_ALARM_EN, alarm armed at 06:30 AM fires exactly once at 06:30:00.
